// File: rtl/logic_unit_pkg.sv
// Shared opcode encoding for the logic unit family.
package logic_unit_pkg;

  localparam int unsigned OP_W = 3;

  typedef logic [OP_W-1:0] op_t;

  // 000..011 keep the legacy sel1:sel0 encoding of the 8-bit combinational unit
  localparam op_t OP_OR   = 3'b000;
  localparam op_t OP_AND  = 3'b001;
  localparam op_t OP_XOR  = 3'b010;
  localparam op_t OP_NOT  = 3'b011;
  localparam op_t OP_NOR  = 3'b100;
  localparam op_t OP_NAND = 3'b101;
  localparam op_t OP_XNOR = 3'b110;
  localparam op_t OP_PASS = 3'b111;

endpackage

// File: rtl/logic_unit_core.sv
// Combinational bitwise operation on operand x and prepared operand b.
module logic_unit_core
  import logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic [WIDTH-1:0] result
);

  // Opcode decode to the selected bitwise function
  always_comb begin
    result = '0;
    case (op)
      OP_OR:   result = x | b;
      OP_AND:  result = x & b;
      OP_XOR:  result = x ^ b;
      OP_NOT:  result = ~x;
      OP_NOR:  result = ~(x | b);
      OP_NAND: result = ~(x & b);
      OP_XNOR: result = ~(x ^ b);
      OP_PASS: result = x;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered logic unit with valid/ready handshake, flags and optional accumulator.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter bit          ACC_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [OP_W-1:0]  op,
  input  logic             acc,
  input  logic             clr_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             zero,
  output logic             parity
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state;
  logic             accept;
  logic             use_acc;
  logic             use_clr;
  logic [WIDTH-1:0] acc_val;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;

  assign out_valid = (state == FULL);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;

  if (ACC_EN) begin : g_acc
    logic [WIDTH-1:0] acc_q;

    assign use_acc = acc;
    assign use_clr = clr_acc;
    assign acc_val = acc_q;

    // Accumulator: an accepted result wins over a standalone clear
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        acc_q <= '0;
      end else if (accept) begin
        acc_q <= result;
      end else if (clr_acc) begin
        acc_q <= '0;
      end
    end
  end else begin : g_no_acc
    logic unused_acc_inputs;

    assign unused_acc_inputs = acc ^ clr_acc;
    assign use_acc = 1'b0;
    assign use_clr = 1'b0;
    assign acc_val = '0;
  end

  // Operand B selection: clear forces zero, else accumulator or y
  always_comb begin
    b = y;
    if (use_acc) b = acc_val;
    if (use_clr) b = '0;
  end

  logic_unit_core #(.WIDTH(WIDTH)) u_core (
    .x      (x),
    .b      (b),
    .op     (op),
    .result (result)
  );

  // Output register occupancy and result/flag capture on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      f      <= '0;
      zero   <= 1'b0;
      parity <= 1'b0;
    end else begin
      case (state)
        EMPTY:   if (accept) state <= FULL;
        FULL:    if (out_ready && !accept) state <= EMPTY;
        default: state <= EMPTY;
      endcase
      if (accept) begin
        f      <= result;
        zero   <= (result == '0);
        parity <= ^result;
      end
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe: main 8-bit instance plus parameter corners.
module tb_logic_unit_pipe;
  import logic_unit_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  // main instance, WIDTH=8, ACC_EN=1
  logic       in_valid, in_ready, acc, clr_acc, out_valid, out_ready, zero, parity;
  logic [7:0] x, y, f;
  logic [2:0] op;

  // WIDTH=1 and WIDTH=32 corner instances share valid/op
  logic        p_valid;
  logic [2:0]  p_op;
  logic [0:0]  x1, y1, f1;
  logic        rdy1, ov1, z1, par1;
  logic [31:0] x32, y32, f32;
  logic        rdy32, ov32, z32, par32;

  // ACC_EN=0 instance
  logic       n_valid, n_acc, n_clr, n_rdy, n_ov, n_zero, n_par;
  logic [7:0] n_x, n_y, n_f;
  logic [2:0] n_op;

  logic_unit_pipe #(.WIDTH(8), .ACC_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .op(op), .acc(acc), .clr_acc(clr_acc),
    .out_valid(out_valid), .out_ready(out_ready), .f(f), .zero(zero), .parity(parity)
  );

  logic_unit_pipe #(.WIDTH(1), .ACC_EN(1'b1)) dut_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(p_valid), .in_ready(rdy1),
    .x(x1), .y(y1), .op(p_op), .acc(1'b0), .clr_acc(1'b0),
    .out_valid(ov1), .out_ready(1'b1), .f(f1), .zero(z1), .parity(par1)
  );

  logic_unit_pipe #(.WIDTH(32), .ACC_EN(1'b1)) dut_w32 (
    .clk(clk), .rst_n(rst_n), .in_valid(p_valid), .in_ready(rdy32),
    .x(x32), .y(y32), .op(p_op), .acc(1'b0), .clr_acc(1'b0),
    .out_valid(ov32), .out_ready(1'b1), .f(f32), .zero(z32), .parity(par32)
  );

  logic_unit_pipe #(.WIDTH(8), .ACC_EN(1'b0)) dut_na (
    .clk(clk), .rst_n(rst_n), .in_valid(n_valid), .in_ready(n_rdy),
    .x(n_x), .y(n_y), .op(n_op), .acc(n_acc), .clr_acc(n_clr),
    .out_valid(n_ov), .out_ready(1'b1), .f(n_f), .zero(n_zero), .parity(n_par)
  );

  // count result beats leaving the main instance
  int out_count = 0;
  always @(posedge clk) if (out_valid && out_ready) out_count <= out_count + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // drive one beat on the main instance and step past the capturing edge
  task automatic send(input logic [7:0] xv, input logic [7:0] yv, input logic [2:0] o,
                      input logic a, input logic c);
    x = xv; y = yv; op = o; acc = a; clr_acc = c; in_valid = 1'b1;
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] ref_op(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] o);
    case (o)
      3'd0:    return a | b;
      3'd1:    return a & b;
      3'd2:    return a ^ b;
      3'd3:    return ~a;
      3'd4:    return ~(a | b);
      3'd5:    return ~(a & b);
      3'd6:    return ~(a ^ b);
      default: return a;
    endcase
  endfunction

  logic [7:0]  sweep_f   [8] = '{8'h7F, 8'h04, 8'h7B, 8'h93, 8'h80, 8'hFB, 8'h84, 8'h6C};
  logic        sweep_par [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [31:0] pat_x     [4] = '{32'hDEADBEEF, 32'hFFFFFFFF, 32'h00000000, 32'h12345678};
  logic [31:0] pat_y     [4] = '{32'h0F0F00FF, 32'h00000000, 32'h00000000, 32'hFFFF0000};

  initial begin
    int sent = 0;
    logic [31:0] e;
    rst_n = 1'b0; in_valid = 1'b0; x = '0; y = '0; op = '0; acc = 1'b0; clr_acc = 1'b0;
    out_ready = 1'b1;
    p_valid = 1'b0; p_op = '0; x1 = '0; y1 = '0; x32 = '0; y32 = '0;
    n_valid = 1'b0; n_x = '0; n_y = '0; n_op = '0; n_acc = 1'b0; n_clr = 1'b0;

    // reset state
    #2;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_f", {24'b0, f}, 32'd0);
    check("rst_zero", {31'b0, zero}, 32'd0);
    check("rst_parity", {31'b0, parity}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // opcode sweep, back-to-back
    for (int i = 0; i < 8; i++) begin
      send(8'h6C, 8'h17, 3'(i), 1'b0, 1'b0);
      sent++;
      check($sformatf("sweep_f_op%0d", i), {24'b0, f}, {24'b0, sweep_f[i]});
      check($sformatf("sweep_par_op%0d", i), {31'b0, parity}, {31'b0, sweep_par[i]});
      check($sformatf("sweep_valid_op%0d", i), {31'b0, out_valid}, 32'd1);
    end

    // backpressure: hold 7F for three cycles while a competing beat waits
    send(8'h6C, 8'h17, OP_OR, 1'b0, 1'b0);
    sent++;
    out_ready = 1'b0;
    x = 8'h6C; y = 8'h17; op = OP_AND;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("bp_in_ready_%0d", i), {31'b0, in_ready}, 32'd0);
      @(posedge clk); #1;
      check($sformatf("bp_hold_f_%0d", i), {24'b0, f}, 32'h7F);
      check($sformatf("bp_hold_valid_%0d", i), {31'b0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    sent++;
    check("bp_release_f", {24'b0, f}, 32'h04);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("bp_drain_valid", {31'b0, out_valid}, 32'd0);
    check("bp_beat_count", out_count, sent);

    // accumulate chain after a standalone clear
    clr_acc = 1'b1;
    @(posedge clk); #1;
    send(8'h0F, 8'hEE, OP_OR, 1'b1, 1'b0);
    check("chain_or_f", {24'b0, f}, 32'h0F);
    send(8'hFF, 8'hEE, OP_XOR, 1'b1, 1'b0);
    check("chain_xor_f", {24'b0, f}, 32'hF0);
    check("chain_xor_valid", {31'b0, out_valid}, 32'd1);
    send(8'h0F, 8'hEE, OP_AND, 1'b1, 1'b0);
    check("chain_and_f", {24'b0, f}, 32'h00);
    check("chain_and_zero", {31'b0, zero}, 32'd1);
    check("chain_and_valid", {31'b0, out_valid}, 32'd1);

    // clear together with accept and acc=1
    send(8'h00, 8'h55, OP_OR, 1'b0, 1'b0);
    check("preload_f", {24'b0, f}, 32'h55);
    send(8'hAA, 8'h00, OP_OR, 1'b1, 1'b1);
    check("clr_accept_f", {24'b0, f}, 32'hAA);
    send(8'h00, 8'h00, OP_OR, 1'b1, 1'b0);
    check("clr_accept_acc_q", {24'b0, f}, 32'hAA);

    // asynchronous reset while FULL
    send(8'h3C, 8'h00, OP_PASS, 1'b0, 1'b0);
    in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_valid", {31'b0, out_valid}, 32'd1);
    check("pre_rst_f", {24'b0, f}, 32'h3C);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    check("mid_rst_f", {24'b0, f}, 32'd0);
    @(posedge clk); #2 rst_n = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    check("post_rst_no_beat", {31'b0, out_valid}, 32'd0);
    send(8'h00, 8'h77, OP_OR, 1'b1, 1'b0);
    check("post_rst_acc_q", {24'b0, f}, 32'h00);
    check("post_rst_zero", {31'b0, zero}, 32'd1);
    send(8'h3C, 8'h0F, OP_XOR, 1'b0, 1'b0);
    check("post_rst_xor_f", {24'b0, f}, 32'h33);
    check("post_rst_xor_par", {31'b0, parity}, 32'd0);
    in_valid = 1'b0;

    // WIDTH=1 and WIDTH=32 opcode sweeps against the reference model
    p_valid = 1'b1;
    for (int o = 0; o < 8; o++) begin
      for (int i = 0; i < 4; i++) begin
        p_op = 3'(o);
        x1 = 1'((i >> 1) & 1); y1 = 1'(i & 1);
        x32 = pat_x[i]; y32 = pat_y[i];
        @(posedge clk); #1;
        e = ref_op({31'b0, x1}, {31'b0, y1}, 3'(o));
        check($sformatf("w1_f_op%0d_v%0d", o, i), {31'b0, f1}, {31'b0, e[0]});
        check($sformatf("w1_zero_op%0d_v%0d", o, i), {31'b0, z1}, {31'b0, ~e[0]});
        e = ref_op(pat_x[i], pat_y[i], 3'(o));
        check($sformatf("w32_f_op%0d_v%0d", o, i), f32, e);
        check($sformatf("w32_zero_op%0d_v%0d", o, i), {31'b0, z32}, {31'b0, e == 32'd0});
        check($sformatf("w32_par_op%0d_v%0d", o, i), {31'b0, par32}, {31'b0, ^e});
      end
    end
    p_valid = 1'b0;

    // ACC_EN=0: acc and clr_acc have no effect, operand B is always y
    n_valid = 1'b1;
    n_x = 8'h0F; n_y = 8'h00; n_op = OP_OR; n_acc = 1'b0; n_clr = 1'b0;
    @(posedge clk); #1;
    check("noacc_first_f", {24'b0, n_f}, 32'h0F);
    n_x = 8'h00; n_y = 8'h33; n_acc = 1'b1;
    @(posedge clk); #1;
    check("noacc_acc_uses_y", {24'b0, n_f}, 32'h33);
    n_y = 8'h55; n_clr = 1'b1;
    @(posedge clk); #1;
    check("noacc_clr_ignored", {24'b0, n_f}, 32'h55);
    n_valid = 1'b0;
    @(posedge clk); #1;
    check("noacc_drain_valid", {31'b0, n_ov}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
